// File: rtl/axi_lite_chk_pkg.sv
// Shared constants and types for the AXI4-Lite register checker.
// Response codes, pattern modes, FSM states and the LFSR step.
package axi_lite_chk_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_WALK  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_NADDR = 2'd3;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_CHECK,
    S_FIN
  } state_t;

  // Right-shifting Galois step: feedback taps applied when bit 0 falls out
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/axi_lite_pattern_gen.sv
// Test pattern source: combinational for counter, walking-one
// and inverted-address modes; registered LFSR for mode 2.
module axi_lite_pattern_gen
  import axi_lite_chk_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [31:0]           seed,
  input  logic [8:0]            index,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  load,
  input  logic                  step,
  output logic [31:0]           pattern
);

  logic [31:0]           lfsr;
  logic [ADDR_WIDTH-1:0] naddr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= 32'h1;
    end else if (load) begin
      lfsr <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_comb begin
    naddr   = ~addr;
    pattern = 32'h0;
    unique case (mode)
      MODE_INC:  pattern = seed + 32'(index);
      MODE_WALK: pattern = 32'h1 << index[4:0];
      MODE_LFSR: pattern = lfsr;
      default:   pattern = 32'(naddr);
    endcase
  end

endmodule

// File: rtl/axi_lite_reg_checker.sv
// AXI4-Lite master sweeping slave registers: write a pattern,
// read it back, compare, and report errors or a timeout.
module axi_lite_reg_checker
  import axi_lite_chk_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    NUM_REGS       = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    ADDR_STRIDE    = 4,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter int                    ERR_CNT_WIDTH  = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [31:0]              seed,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [31:0]              first_err_data,
  output logic [ADDR_WIDTH-1:0]    M_AXI_AWADDR,
  output logic [2:0]               M_AXI_AWPROT,
  output logic                     M_AXI_AWVALID,
  input  logic                     M_AXI_AWREADY,
  output logic [31:0]              M_AXI_WDATA,
  output logic [3:0]               M_AXI_WSTRB,
  output logic                     M_AXI_WVALID,
  input  logic                     M_AXI_WREADY,
  input  logic [1:0]               M_AXI_BRESP,
  input  logic                     M_AXI_BVALID,
  output logic                     M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]    M_AXI_ARADDR,
  output logic [2:0]               M_AXI_ARPROT,
  output logic                     M_AXI_ARVALID,
  input  logic                     M_AXI_ARREADY,
  input  logic [31:0]              M_AXI_RDATA,
  input  logic [1:0]               M_AXI_RRESP,
  input  logic                     M_AXI_RVALID,
  output logic                     M_AXI_RREADY
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state, nxt;
  logic [TW-1:0]           cnt;
  logic [8:0]              idx;
  logic [1:0]              mode_q;
  logic [31:0]             seed_q;
  logic                    wr_go, awv, wv;
  logic                    b_err;
  logic [31:0]             rdata_q;
  logic [1:0]              rresp_q;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [31:0]             pat;
  logic                    in_hs, tmo_hit, wr_fin;
  logic                    last, r_err, chk_err;

  assign addr = BASE_ADDR
              + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STRIDE);

  assign in_hs   = state inside {S_WR, S_WRESP, S_RADDR, S_RDATA};
  assign tmo_hit = in_hs && (cnt == TW'(TIMEOUT_CYCLES - 1));
  assign wr_fin  = wr_go
                && (!awv || M_AXI_AWREADY)
                && (!wv  || M_AXI_WREADY);
  assign last    = (idx == 9'(NUM_REGS - 1));
  assign r_err   = b_err || (rresp_q != RESP_OKAY);
  assign chk_err = r_err || (rdata_q != pat);

  axi_lite_pattern_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pat (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .mode    (mode_q),
    .seed    (seed_q),
    .index   (idx),
    .addr    (addr),
    .load    (state == S_WR && idx == 9'd0 && !wr_go),
    .step    (state == S_CHECK),
    .pattern (pat)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = S_WR;
      S_WR:    if (wr_fin) nxt = S_WRESP;
               else if (tmo_hit) nxt = S_FIN;
      S_WRESP: if (M_AXI_BVALID) nxt = S_RADDR;
               else if (tmo_hit) nxt = S_FIN;
      S_RADDR: if (M_AXI_ARREADY) nxt = S_RDATA;
               else if (tmo_hit) nxt = S_FIN;
      S_RDATA: if (M_AXI_RVALID) nxt = S_CHECK;
               else if (tmo_hit) nxt = S_FIN;
      S_CHECK: nxt = last ? S_FIN : S_WR;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cnt            <= '0;
      idx            <= '0;
      mode_q         <= '0;
      seed_q         <= '0;
      wr_go          <= 1'b0;
      awv            <= 1'b0;
      wv             <= 1'b0;
      b_err          <= 1'b0;
      rdata_q        <= '0;
      rresp_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      cnt   <= (nxt != state || !in_hs) ? '0 : cnt + 1'b1;
      wr_go <= (state == S_WR) && (nxt == S_WR);
      // Valids rise one cycle after WR entry, then fall per channel
      if (state == S_WR && nxt == S_WR && !wr_go) begin
        awv <= 1'b1;
        wv  <= 1'b1;
      end else begin
        if (M_AXI_AWREADY || nxt != S_WR) awv <= 1'b0;
        if (M_AXI_WREADY  || nxt != S_WR) wv  <= 1'b0;
      end
      if (in_hs && nxt == S_FIN) timeout <= 1'b1;
      unique case (state)
        S_IDLE: if (start) begin
          mode_q         <= mode;
          seed_q         <= seed;
          idx            <= '0;
          busy           <= 1'b1;
          done           <= 1'b0;
          pass           <= 1'b0;
          timeout        <= 1'b0;
          err_count      <= '0;
          first_err_addr <= '0;
          first_err_data <= '0;
        end
        S_WRESP: if (M_AXI_BVALID) begin
          b_err <= (M_AXI_BRESP != RESP_OKAY);
        end
        S_RDATA: if (M_AXI_RVALID) begin
          rdata_q <= M_AXI_RDATA;
          rresp_q <= M_AXI_RRESP;
        end
        S_CHECK: begin
          idx <= idx + 1'b1;
          if (chk_err) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              first_err_addr <= addr;
              first_err_data <= r_err ? 32'h0 : rdata_q;
            end
          end
        end
        S_FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (err_count == '0) && !timeout;
        end
        default: ;
      endcase
    end
  end

  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awv;
  assign M_AXI_WDATA   = pat;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wv;
  assign M_AXI_BREADY  = (state == S_WRESP);
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state == S_RADDR);
  assign M_AXI_RREADY  = (state == S_RDATA);

endmodule

// File: tb/tb_axi_lite_reg_checker.sv
// Bench for axi_lite_reg_checker: behavioural slave with fault knobs,
// a sweep-level reference model and a per-cycle handshake checker.
module tb_axi_lite_reg_checker;

  localparam int NREG = 8;
  localparam int TMO  = 16;

  logic        tb_ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] seed = 32'h0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr, first_err_data;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
  logic        BVALID = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_reg_checker #(
    .ADDR_WIDTH(32), .NUM_REGS(NREG), .BASE_ADDR(32'h0),
    .ADDR_STRIDE(4), .TIMEOUT_CYCLES(TMO), .ERR_CNT_WIDTH(16)
  ) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN), .start(start), .mode(mode),
    .seed(seed), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT),
    .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave fault knobs
  bit          rand_en = 0;
  bit          aw_block = 0;
  int          stuck_reg = -1;
  logic [31:0] stuck_mask = 32'h0;
  int          slverr_addr = -1;

  // Behavioural slave: samples handshakes mid-cycle, drives after the edge
  initial begin
    logic [31:0] mem [NREG];
    logic        aw_h, w_h, ar_h, rst_s;
    logic        h_aw, h_w, h_b, h_ar, h_r;
    logic [31:0] aw_a, w_d, ar_a, s_aw, s_w, s_ar;
    int          k;
    aw_h = 0; w_h = 0; ar_h = 0;
    aw_a = 0; w_d = 0; ar_a = 0;
    for (int i = 0; i < NREG; i++) mem[i] = 32'h0;
    forever begin
      @(negedge tb_ACLK);
      rst_s = !ARESETN;
      h_aw = AWVALID && AWREADY; s_aw = AWADDR;
      h_w  = WVALID && WREADY;   s_w  = WDATA;
      h_b  = BVALID && BREADY;
      h_ar = ARVALID && ARREADY; s_ar = ARADDR;
      h_r  = RVALID && RREADY;
      @(posedge tb_ACLK);
      #1;
      if (rst_s) begin
        aw_h = 0; w_h = 0; ar_h = 0;
        BVALID = 0; RVALID = 0;
      end else begin
        if (h_aw) begin aw_h = 1; aw_a = s_aw; end
        if (h_w)  begin w_h = 1;  w_d = s_w;   end
        if (h_ar) begin ar_h = 1; ar_a = s_ar; end
        if (h_b) BVALID = 0;
        if (h_r) RVALID = 0;
        if (aw_h && w_h && !BVALID
            && (!rand_en || $urandom_range(0, 3) != 0)) begin
          k = int'(aw_a[4:2]);
          mem[k] = (k == stuck_reg) ? (w_d & ~stuck_mask) : w_d;
          BRESP  = (aw_a == 32'(slverr_addr)) ? 2'b10 : 2'b00;
          BVALID = 1;
          aw_h = 0; w_h = 0;
        end
        if (ar_h && !RVALID
            && (!rand_en || $urandom_range(0, 3) != 0)) begin
          RDATA  = mem[int'(ar_a[4:2])];
          RRESP  = 2'b00;
          RVALID = 1;
          ar_h = 0;
        end
      end
      AWREADY = !aw_h && !aw_block
             && (!rand_en || $urandom_range(0, 2) != 0);
      WREADY  = !w_h && (!rand_en || $urandom_range(0, 2) != 0);
      ARREADY = !ar_h && (!rand_en || $urandom_range(0, 2) != 0);
    end
  end

  // Reference model: what one sweep must write and report
  logic [31:0] exp_addr [NREG];
  logic [31:0] exp_data [NREG];
  int          e_err;
  logic [31:0] e_fa, e_fd;
  bit          e_tmo, e_pass;
  int          aw_n = 0, w_n = 0, ar_n = 0;

  function automatic logic [31:0] model_pat(input int m,
      input logic [31:0] s, input int i);
    logic [31:0] r;
    r = (s == 0) ? 32'h1 : s;
    case (m)
      0: return s + 32'(i);
      1: return 32'h1 << (i % 32);
      2: begin
        for (int k = 0; k < i; k++)
          r = (r >> 1) ^ (r[0] ? 32'h8020_0003 : 32'h0);
        return r;
      end
      default: return ~(32'(i * 4));
    endcase
  endfunction

  task automatic model_sweep(input int m, input logic [31:0] s);
    logic [31:0] p, rd;
    bit be;
    e_err = 0; e_fa = 0; e_fd = 0;
    e_tmo = aw_block;
    for (int i = 0; i < NREG; i++) begin
      p  = model_pat(m, s, i);
      exp_addr[i] = 32'(i * 4);
      exp_data[i] = p;
      rd = (i == stuck_reg) ? (p & ~stuck_mask) : p;
      be = (i * 4 == slverr_addr);
      if (be || rd != p) begin
        if (e_err == 0) begin
          e_fa = 32'(i * 4);
          e_fd = be ? 32'h0 : rd;
        end
        e_err++;
      end
    end
    if (e_tmo) begin e_err = 0; e_fa = 0; e_fd = 0; end
    e_pass = (e_err == 0) && !e_tmo;
  endtask

  // Per-cycle compare of handshakes against the model stream
  initial begin
    forever begin
      @(negedge tb_ACLK);
      if (ARESETN) begin
        if (AWVALID && AWREADY) begin
          if (aw_n < NREG) check("awaddr", AWADDR, exp_addr[aw_n]);
          else check("aw_extra", 64'(aw_n), 64'(NREG - 1));
          check("awprot", AWPROT, 3'b000);
          aw_n++;
        end
        if (WVALID && WREADY) begin
          if (w_n < NREG) check("wdata", WDATA, exp_data[w_n]);
          else check("w_extra", 64'(w_n), 64'(NREG - 1));
          check("wstrb", WSTRB, 4'hF);
          w_n++;
        end
        if (ARVALID && ARREADY) begin
          if (ar_n < NREG) check("araddr", ARADDR, exp_addr[ar_n]);
          else check("ar_extra", 64'(ar_n), 64'(NREG - 1));
          check("arprot", ARPROT, 3'b000);
          ar_n++;
        end
        if (timeout)
          check("tmo_valids", {AWVALID, WVALID, ARVALID}, 3'b000);
      end
    end
  end

  task automatic start_sweep(input int m, input logic [31:0] s);
    @(negedge tb_ACLK);
    model_sweep(m, s);
    aw_n = 0; w_n = 0; ar_n = 0;
    mode = 2'(m); seed = s; start = 1;
    @(negedge tb_ACLK);
    start = 0;
  endtask

  int last_cyc;

  task automatic run_sweep(input string tag, input int m,
                           input logic [31:0] s);
    start_sweep(m, s);
    last_cyc = 1;
    while (!done && last_cyc < 1000) begin
      @(negedge tb_ACLK);
      last_cyc++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_pass"}, pass, e_pass);
    check({tag, "_tmo"}, timeout, e_tmo);
    check({tag, "_errcnt"}, err_count, 16'(e_err));
    check({tag, "_faddr"}, first_err_addr, e_fa);
    check({tag, "_fdata"}, first_err_data, e_fd);
    if (!e_tmo) check({tag, "_awcount"}, 64'(aw_n), 64'(NREG));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valids"},
          {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
    check({tag, "_flags"}, {busy, done, pass, timeout}, 4'b0);
    check({tag, "_err"}, {err_count, first_err_addr, first_err_data},
          '0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge tb_ACLK);
    ARESETN = 1;
    @(negedge tb_ACLK);
    check_idle("reset");

    // Hand-computed values that pin the model itself
    check("pin_m0_r0", model_pat(0, 32'h0101FFFF, 0), 32'h0101FFFF);
    check("pin_m0_r3", model_pat(0, 32'h0101FFFF, 3), 32'h01020002);
    check("pin_m1_r2", model_pat(1, 32'h0, 2), 32'h4);
    check("pin_m2_r0", model_pat(2, 32'h0, 0), 32'h1);
    check("pin_m2_r1", model_pat(2, 32'h0, 1), 32'h80200003);
    check("pin_m2_r2", model_pat(2, 32'h0, 2), 32'hC0300002);
    check("pin_m3_r3", model_pat(3, 32'h0, 3), 32'hFFFFFFF3);

    run_sweep("inc", 0, 32'h0101FFFF);
    check("inc_lit_pass", pass, 1'b1);

    stuck_reg = 2; stuck_mask = 32'h4;
    run_sweep("walk", 1, 32'h0);
    check("walk_lit", {err_count, first_err_addr, first_err_data},
          {16'd1, 32'h8, 32'h0});
    stuck_reg = -1; stuck_mask = 0;

    slverr_addr = 32'hC;
    run_sweep("slverr", 0, 32'h1234_5678);
    check("slverr_lit", {err_count, first_err_addr, pass},
          {16'd1, 32'hC, 1'b0});
    slverr_addr = -1;

    aw_block = 1;
    run_sweep("tmo", 2, 32'hDEAD_BEEF);
    check("tmo_latency", last_cyc <= TMO + 2, 1'b1);
    check("tmo_lit", {timeout, pass}, 2'b10);
    aw_block = 0;
    ARESETN = 0;
    @(negedge tb_ACLK);
    ARESETN = 1;

    rand_en = 1;
    for (int r = 0; r < 3; r++)
      run_sweep("lfsr", 2, 32'h0);
    check("lfsr_lit_pass", pass, 1'b1);
    run_sweep("rnd_inc", 0, $urandom);
    run_sweep("rnd_naddr", 3, $urandom);

    // Abort during RDATA of reg 1 with an error already counted
    slverr_addr = 0;
    start_sweep(0, 32'h5);
    n = 0;
    while (!(RREADY && ar_n == 2) && n < 200) begin
      @(negedge tb_ACLK);
      n++;
    end
    check("abort_reached", n < 200, 1'b1);
    ARESETN = 0;
    @(negedge tb_ACLK);
    check_idle("abort");
    ARESETN = 1;
    slverr_addr = -1;
    repeat (3) @(negedge tb_ACLK);
    check("abort_quiet", {AWVALID, WVALID, ARVALID}, 3'b0);
    run_sweep("after_rst", 3, 32'h0);
    check("after_rst_pass", pass, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
